// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// default sizes, FSM state type and the BCD digit range check.
package bcd_pkg;

   localparam int BCD_DIGITS = 3;
   localparam int BCD_BIN_W  = 10;

   typedef enum logic {IDLE, SHIFT} state_e;

   function automatic logic bcd_digit_valid(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_to_bin_digit_adj.sv
// Per-digit correction for reverse double-dabble: a digit that picked up
// a weight-8 bit from its upper neighbour really carries weight 5, so take 3 off.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] d_in,
   output logic [3:0] d_out
);

   assign d_out = (d_in >= 4'd8) ? (d_in - 4'd3) : d_in;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one shift per cycle, start/busy/done.
// Optional input digit check: define BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int DIGITS = BCD_DIGITS,
   parameter int BIN_W  = BCD_BIN_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BCD_W = 4*DIGITS;
   localparam int CNT_W = $clog2(BIN_W+1);

   state_e             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [BIN_W-1:0]   bin_out_q, bin_out_d;

   logic [BCD_W+BIN_W-1:0] work_sh;
   logic [BCD_W-1:0]       bcd_adj;

   assign work_sh = {bcd_q, bin_q} >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_in  (work_sh[BIN_W + 4*g +: 4]),
         .d_out (bcd_adj[4*g +: 4])
      );
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic bad_digit;
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (!bcd_digit_valid(bcd_in[4*i +: 4])) bad_digit = 1'b1;
   end
`endif

   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      bin_out_d = bin_out_q;
      case (state_q)
         IDLE: if (start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (bad_digit) begin
               bin_out_d = '0;
               err_d     = 1'b1;
               done_d    = 1'b1;
            end else begin
`else
            begin
`endif
               bcd_d   = bcd_in;
               bin_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            bcd_d = bcd_adj;
            bin_d = work_sh[BIN_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W-1)) begin
               bin_out_d = work_sh[BIN_W-1:0];
               err_d     = 1'b0;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         bin_out_q <= '0;
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         bin_out_q <= bin_out_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin (DIGITS=3, BIN_W=10), expected values by hand.
module tb_bcd_to_bin;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] bcd_in;
   logic        busy, done, err;
   logic [9:0]  bin_out;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .busy(busy), .done(done), .bin_out(bin_out), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept at E0, busy through E9, done/result after E10; no trailing tick,
   // so a following call is accepted at E11.
   task automatic convert(input logic [11:0] bcd, input logic [9:0] exp, input string tag);
      start  = 1'b1;
      bcd_in = bcd;
      tick();
      start  = 1'b0;
      bcd_in = ~bcd;
      check({tag, "_e0_busy_done"}, {busy, done}, 2'b10);
      for (int k = 1; k < 10; k++) begin
         tick();
         check({tag, "_busy_done"}, {busy, done}, 2'b10);
      end
      tick();
      check({tag, "_fin_busy_done_err"}, {busy, done, err}, 3'b010);
      check({tag, "_bin_out"}, bin_out, exp);
   endtask

   initial begin
      int dones;
      bit seen;

      rst = 1'b1; start = 1'b0; bcd_in = '0;
      #3;
      check("rst_outputs", {busy, done, err, bin_out}, 13'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("idle_outputs", {busy, done, err, bin_out}, 13'd0);
      end

      convert(12'h999, 10'd999, "c999");
      tick();
      check("c999_done_drop", {busy, done}, 2'b00);

      convert(12'h000, 10'd0, "c000");
      convert(12'h512, 10'd512, "c512");
      convert(12'h007, 10'd7, "c007");
      tick();
      check("seq_done_drop", {busy, done}, 2'b00);

`ifdef BCD2BIN_DIGIT_CHECK_EN
      start = 1'b1; bcd_in = 12'h1A5;
      tick();
      start = 1'b0;
      check("bad_e0", {busy, done, err, bin_out}, {3'b011, 10'd0});
      tick();
      check("bad_after", {busy, done}, 2'b00);
`else
      start = 1'b1; bcd_in = 12'h1A5;
      tick();
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         check("bad_nochk_busy", {busy, done}, 2'b10);
         tick();
      end
      check("bad_nochk_fin", {busy, done, err}, 3'b010);
      tick();
`endif

      // Mid-conversion re-start is ignored; exactly one done, result 456.
      start = 1'b1; bcd_in = 12'h456;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int k = 1; k < 20 && !seen; k++) begin
         if (k == 3) begin start = 1'b1; bcd_in = 12'h123; end
         tick();
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check("mid_done_seen", {31'd0, seen}, 32'd1);
      check("mid_bin_out", bin_out, 10'd456);
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done) dones++;
      end
      check("mid_extra_dones", dones, 0);
      check("mid_hold_bin_out", bin_out, 10'd456);

      // Reset during SHIFT aborts with no done.
      start = 1'b1; bcd_in = 12'h321;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      #2 rst = 1'b1;
      #1;
      check("rst_mid_outputs", {busy, done, err, bin_out}, 13'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 13; k++) begin
         tick();
         if (done || busy) dones++;
      end
      check("rst_mid_no_done", dones, 0);

      convert(12'h321, 10'd321, "c321");
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
